imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 in_valid  input  1  source presents a program byte.
REQ-006 in_data  input  8  program byte, big-endian within each instruction word (first byte = bits 31:24).
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 we  output  1  byte-write strobe to the instruction memory write port.
REQ-009 waddr  output  10  byte address of the write (0..1023).
REQ-010 wdata  output  8  byte to write.
REQ-011 busy  output  1  high while in LOAD.
REQ-012 done  output  1  high while in DONE.
REQ-013 err  output  1  load ended on a full memory without a terminator word.
REQ-014 cpu_hold  output  1  holds the core off while the program image is not valid.
REQ-015 word_count  output  9  complete 32-bit words written in the current or last load (0..256).

Function
REQ-016 States SHALL be IDLE, LOAD and DONE; reset enters IDLE.
REQ-017 IDLE: start=1 -> LOAD next cycle; byte pointer, word_count and err cleared to 0.
REQ-018 LOAD: start SHALL be ignored.
REQ-019 DONE: start=1 -> LOAD with the same clearing as REQ-017.
REQ-020 in_ready SHALL equal (state==LOAD), combinationally; accept = in_valid & in_ready.
REQ-021 On an accept, the next cycle SHALL have we=1, waddr=pointer, wdata=in_data; pointer increments by 1.
REQ-022 On any cycle without an accept, we SHALL be 0 next cycle; waddr/wdata hold their last values.
REQ-023 Accepted bytes SHALL shift into a 32-bit assembly register, first byte ending in bits 31:24.
REQ-024 Completion: an accept with pointer[1:0]==3 completes a word; word_count increments by 1 next cycle.
REQ-025 Terminator: if a completed word (assembly[23:0] concatenated with in_data) equals 32'h00000000, state SHALL go to DONE next cycle, err=0.
REQ-026 The terminator word SHALL itself be written, so the memory image carries the halt word.
REQ-027 Overflow: a non-terminator word completed at pointer==1023 SHALL go to DONE next cycle with err=1.
REQ-028 The pointer SHALL never wrap inside a load.
REQ-029 Terminator completed at pointer==1023 SHALL give DONE with err=0.
REQ-030 busy=(state==LOAD), done=(state==DONE), cpu_hold=(state!=DONE); all registered-state decodes, no input paths.
REQ-031 Single-byte gaps or arbitrary in_valid gaps SHALL not alter written data or addresses.
REQ-032 Max one byte per cycle; a byte write is complete one cycle after accept (latency 1).

Reset
REQ-033 On rst=1, regardless of state, next cycle: state=IDLE, pointer=0, assembly=0, we=0, waddr=0, wdata=0, word_count=0, err=0, busy=0, done=0, cpu_hold=1, in_ready=0.
REQ-034 A load interrupted by rst SHALL NOT resume; a new start is required and restarts at address 0.
REQ-035 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-036 start, then bytes 00 90 05 13 00 00 00 00 back-to-back -> writes addr0..7 = 00,90,05,13,00,00,00,00; DONE one cycle after 8th accept; word_count=2; err=0; cpu_hold falls with done.
REQ-037 Same stream with in_valid low on alternate cycles -> identical writes and addresses; we pulses only on cycles after accepts.
REQ-038 start, then 1024 bytes of 0x13 -> 1024 writes (addr 0..1023); DONE with err=1; word_count=256; in_ready=0 afterward.
REQ-039 rst asserted after 5 bytes accepted -> IDLE, cpu_hold=1, word_count=0; new start + 00 00 00 00 writes addr0..3 and gives DONE with word_count=1.
REQ-040 start pulsed during LOAD -> no effect on pointer; start pulsed in DONE -> LOAD, word_count=0, err=0, next write at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams program bytes into a byte-wide write port,
// counts completed 32-bit words and stops on an all-zero terminator word or a full memory.
module imem_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       we,
    output logic [9:0] waddr,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cpu_hold,
    output logic [8:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t      state;
    logic [9:0]  ptr;
    logic [31:0] assembly;

    logic        accept;
    logic        word_end;
    logic [31:0] next_word;

    assign in_ready  = (state == LOAD);
    assign accept    = in_valid & in_ready;
    assign next_word = {assembly[23:0], in_data};
    assign word_end  = accept & (ptr[1:0] == 2'd3);

    // busy/done/cpu_hold are flops updated alongside every state change,
    // so the core-facing controls never see an input-to-output path.
    // NOTE: every register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            assembly   <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            word_count <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            we <= 1'b0;
            if (accept) begin
                we       <= 1'b1;
                waddr    <= ptr;
                wdata    <= in_data;
                assembly <= next_word;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        assembly   <= '0;
                        word_count <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (word_end) begin
                            word_count <= word_count + 9'd1;
                        end
                        if (word_end && (next_word == 32'h0000_0000)) begin
                            state    <= DONE;
                            err      <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (word_end && (ptr == 10'd1023)) begin
                            state    <= DONE;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                        // Pointer saturates at the last byte; a load never wraps.
                        if (ptr != 10'd1023) begin
                            ptr <= ptr + 10'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor
// pops and compares them on every we pulse; status outputs are checked directly.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       cpu_hold;
    logic [8:0] word_count;

    int n_pass = 0;
    int n_total = 0;
    int addr_m = 0;
    logic [17:0] exp_q[$];

    imem_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .cpu_hold(cpu_hold),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {14'd0, waddr, wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("write_addr", {22'd0, waddr}, {22'd0, e[17:8]});
                check("write_data", {24'd0, wdata}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        addr_m = 0;
    endtask

    // One byte presented while in LOAD; it is accepted on the next edge.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        exp_q.push_back({addr_m[9:0], b});
        addr_m++;
        tick();
        in_valid = 1'b0;
    endtask

    logic [7:0] prog[8] = '{8'h00, 8'h90, 8'h05, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {22'd0, waddr}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_word_count", {23'd0, word_count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back terminated program.
        do_start();
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(prog[i]);
            if (i == 3) check("wc_after_word0", {23'd0, word_count}, 32'd1);
        end
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_word_count", {23'd0, word_count}, 32'd2);
        check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        tick(); tick();

        // Restart from DONE, same stream with alternate-cycle gaps.
        do_start();
        check("t2_wc_clear", {23'd0, word_count}, 32'd0);
        check("t2_done_clear", {31'd0, done}, 32'd0);
        check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(prog[i]);
            if (i != 7) tick();
        end
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_word_count", {23'd0, word_count}, 32'd2);
        tick(); tick();

        // start pulsed mid-load must not disturb the pointer.
        do_start();
        send(8'h00);
        send(8'h11);
        start = 1'b1;
        send(8'h22);
        start = 1'b0;
        send(8'h33);
        check("t3_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send(8'h00);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_word_count", {23'd0, word_count}, 32'd2);
        tick(); tick();

        // Reset mid-load, idle bytes ignored, fresh load from address 0.
        do_start();
        for (int i = 0; i < 5; i++) send(8'h13);
        rst = 1'b1;
        in_valid = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("t4_word_count", {23'd0, word_count}, 32'd0);
        check("t4_in_ready", {31'd0, in_ready}, 32'd0);
        tick(); tick();
        in_valid = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++) send(8'h00);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_word_count_new", {23'd0, word_count}, 32'd1);
        tick(); tick();

        // Full memory without terminator.
        do_start();
        for (int i = 0; i < 1024; i++) send(8'h13);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_word_count", {23'd0, word_count}, 32'd256);
        check("t5_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("t5_last_waddr", {22'd0, waddr}, 32'd1023);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
